mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 79 +++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-memory arbiter bus: fetch port, data port and the single-port memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_BIT_WIDTH = 30,
    parameter int unsigned DATA_BIT_WIDTH = 32
);
    logic                      i_req;
    logic [ADDR_BIT_WIDTH-1:0] i_addr;
    logic                      i_gnt;
    logic                      i_rvalid;
    logic [DATA_BIT_WIDTH-1:0] i_rdata;

    logic                      d_req;
    logic                      d_we;
    logic                      d_lock;
    logic [ADDR_BIT_WIDTH-1:0] d_addr;
    logic [DATA_BIT_WIDTH-1:0] d_wdata;
    logic                      d_gnt;
    logic                      d_rvalid;
    logic [DATA_BIT_WIDTH-1:0] d_rdata;

    logic [ADDR_BIT_WIDTH-1:0] mem_addr;
    logic [DATA_BIT_WIDTH-1:0] mem_wdata;
    logic                      mem_en_write;
    logic [DATA_BIT_WIDTH-1:0] mem_rdata;

    // Arbiter side.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_wdata, mem_en_write
    );

    // Requester/memory side.
    modport master (
        output i_req, i_addr, d_req, d_we, d_lock, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_wdata, mem_en_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a fetch port and a
// data port, with a data-port lock that excludes fetches.
module mem_arbiter #(
    parameter int unsigned ADDR_BIT_WIDTH = 30,
    parameter int unsigned DATA_BIT_WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLastI, StLastD, StLocked} state_e;

    state_e                    state_q, state_d;
    logic                      i_gnt, d_gnt;
    logic                      i_rvalid_q, d_rvalid_q;
    logic [DATA_BIT_WIDTH-1:0] i_rdata_q, d_rdata_q;
    logic [ADDR_BIT_WIDTH-1:0] mem_addr;

    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;
        if (!reset) begin
            if (state_q == StLocked) begin
                d_gnt = bus.d_req;
            end else if (bus.i_req && bus.d_req) begin
                // Data wins unless it won last time.
                d_gnt = (state_q != StLastD);
                i_gnt = (state_q == StLastD);
            end else begin
                i_gnt = bus.i_req;
                d_gnt = bus.d_req;
            end
        end

        if (reset) begin
            state_d = StIdle;
        end else if (i_gnt) begin
            state_d = StLastI;
        end else if (d_gnt) begin
            state_d = bus.d_lock ? StLocked : StLastD;
        end else if (state_q == StLocked && !bus.d_lock) begin
            // Lock dropped without a final access.
            state_d = StLastD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            i_rvalid_q <= i_gnt;
            d_rvalid_q <= d_gnt;
            if (i_gnt) begin
                i_rdata_q <= bus.mem_rdata;
            end
            // Write acks leave the read data untouched.
            if (d_gnt && !bus.d_we) begin
                d_rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign mem_addr         = d_gnt ? bus.d_addr : bus.i_addr;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = bus.d_wdata;
    assign bus.mem_en_write = d_gnt & bus.d_we;
    assign bus.i_gnt        = i_gnt;
    assign bus.d_gnt        = d_gnt;
    assign bus.i_rvalid     = i_rvalid_q;
    assign bus.d_rvalid     = d_rvalid_q;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle comparison against a priority/lock
// model plus literal checks of the documented scenarios.
module tb_mem_arbiter;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) bus ();

    mem_arbiter #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who wins a tie, whether the data port holds the lock, last read data.
    logic          m_locked, m_dfirst, m_irv, m_drv;
    logic [DW-1:0] m_irdata, m_drdata;
    logic          e_ig, e_dg;

    always @(negedge clk) begin
        if (reset) begin
            e_ig = 1'b0;
            e_dg = 1'b0;
        end else if (m_locked) begin
            e_ig = 1'b0;
            e_dg = bus.d_req;
        end else if (bus.i_req && bus.d_req) begin
            e_dg = m_dfirst;
            e_ig = !m_dfirst;
        end else begin
            e_ig = bus.i_req;
            e_dg = bus.d_req;
        end
        chk("i_gnt", 64'(bus.i_gnt), 64'(e_ig));
        chk("d_gnt", 64'(bus.d_gnt), 64'(e_dg));
        chk("one_grant", 64'(bus.i_gnt & bus.d_gnt), 64'd0);
        chk("mem_addr", 64'(bus.mem_addr), 64'(e_dg ? bus.d_addr : bus.i_addr));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(bus.d_wdata));
        chk("mem_en_write", 64'(bus.mem_en_write), 64'(e_dg && bus.d_we));
        chk("i_rvalid", 64'(bus.i_rvalid), 64'(m_irv));
        chk("d_rvalid", 64'(bus.d_rvalid), 64'(m_drv));
        chk("i_rdata", 64'(bus.i_rdata), 64'(m_irdata));
        chk("d_rdata", 64'(bus.d_rdata), 64'(m_drdata));
    end

    always @(posedge clk) begin
        if (reset) begin
            m_locked <= 1'b0;
            m_dfirst <= 1'b1;
            m_irv    <= 1'b0;
            m_drv    <= 1'b0;
            m_irdata <= '0;
            m_drdata <= '0;
        end else begin
            m_irv <= e_ig;
            m_drv <= e_dg;
            if (e_ig) begin
                m_irdata <= bus.mem_rdata;
                m_dfirst <= 1'b1;
            end
            if (e_dg) begin
                if (!bus.d_we) m_drdata <= bus.mem_rdata;
                m_dfirst <= 1'b0;
                m_locked <= bus.d_lock;
            end else if (m_locked && !bus.d_req && !bus.d_lock) begin
                m_locked <= 1'b0;
                m_dfirst <= 1'b0;
            end
        end
    end

    task automatic set_in(input logic ir, input logic [AW-1:0] ia, input logic dr,
                          input logic dw, input logic dl, input logic [AW-1:0] da,
                          input logic [DW-1:0] dwd, input logic [DW-1:0] mrd);
        bus.i_req     = ir;
        bus.i_addr    = ia;
        bus.d_req     = dr;
        bus.d_we      = dw;
        bus.d_lock    = dl;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        bus.mem_rdata = mrd;
        #1;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 32'h5555_AAAA);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both ports requesting: no grants.
        reset = 1'b1;
        set_in(1'b1, 30'h4, 1'b1, 1'b0, 1'b0, 30'h8, 32'h0, 32'h1111_1111);
        chk("rst_i_gnt", 64'(bus.i_gnt), 64'd0);
        chk("rst_d_gnt", 64'(bus.d_gnt), 64'd0);
        tick();
        tick();
        chk("rst_d_rdata", 64'(bus.d_rdata), 64'd0);
        reset = 1'b0;

        // Contention for 4 cycles: d, i, d, i.
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 30'h4, 1'b1, 1'b0, 1'b0, 30'h8, 32'h0, 32'hA0A0_0000 + DW'(k));
            chk("contend_d_gnt", 64'(bus.d_gnt), 64'((k % 2) == 0));
            chk("contend_i_gnt", 64'(bus.i_gnt), 64'((k % 2) == 1));
            tick();
        end
        idle_in();
        tick();

        // Fetch only.
        set_in(1'b1, 30'h10, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 32'hDEAD_BEEF);
        chk("fetch_gnt", 64'(bus.i_gnt), 64'd1);
        tick();
        idle_in();
        chk("fetch_rvalid", 64'(bus.i_rvalid), 64'd1);
        chk("fetch_rdata", 64'(bus.i_rdata), 64'hDEAD_BEEF);
        tick();
        chk("fetch_rvalid_off", 64'(bus.i_rvalid), 64'd0);

        // Data write: ack pulses, read data keeps last d read (contention cycle 2).
        set_in(1'b0, 30'h0, 1'b1, 1'b1, 1'b0, 30'h20, 32'h1234_5678, 32'h0BAD_0BAD);
        chk("wr_en", 64'(bus.mem_en_write), 64'd1);
        chk("wr_addr", 64'(bus.mem_addr), 64'h20);
        chk("wr_wdata", 64'(bus.mem_wdata), 64'h1234_5678);
        tick();
        idle_in();
        chk("wr_ack", 64'(bus.d_rvalid), 64'd1);
        chk("wr_rdata_kept", 64'(bus.d_rdata), 64'hA0A0_0002);
        tick();

        // Lock: fetch stays blocked until the unlocking write.
        set_in(1'b0, 30'h0, 1'b1, 1'b0, 1'b1, 30'h30, 32'h0, 32'hC0DE_0001);
        tick();
        set_in(1'b1, 30'h14, 1'b0, 1'b0, 1'b1, 30'h30, 32'h0, 32'h0);
        chk("lock_c1_i_gnt", 64'(bus.i_gnt), 64'd0);
        tick();
        chk("lock_c2_i_gnt", 64'(bus.i_gnt), 64'd0);
        tick();
        set_in(1'b1, 30'h14, 1'b1, 1'b1, 1'b0, 30'h34, 32'h7777_0000, 32'h0);
        chk("lock_c3_i_gnt", 64'(bus.i_gnt), 64'd0);
        chk("lock_c3_d_gnt", 64'(bus.d_gnt), 64'd1);
        tick();
        set_in(1'b1, 30'h14, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 32'h4444_0004);
        chk("lock_c4_i_gnt", 64'(bus.i_gnt), 64'd1);
        tick();

        // Reset while locked releases the lock.
        set_in(1'b0, 30'h0, 1'b1, 1'b0, 1'b1, 30'h40, 32'h0, 32'hC0DE_0002);
        tick();
        set_in(1'b0, 30'h0, 1'b0, 1'b0, 1'b1, 30'h40, 32'h0, 32'h0);
        tick();
        reset = 1'b1;
        set_in(1'b1, 30'h18, 1'b0, 1'b0, 1'b1, 30'h40, 32'h0, 32'h0);
        chk("rstlock_i_gnt", 64'(bus.i_gnt), 64'd0);
        chk("rstlock_i_rvalid", 64'(bus.i_rvalid), 64'd0);
        chk("rstlock_d_rvalid", 64'(bus.d_rvalid), 64'd0);
        tick();
        reset = 1'b0;
        set_in(1'b1, 30'h18, 1'b0, 1'b0, 1'b1, 30'h40, 32'h0, 32'h9999_0009);
        chk("postrst_i_gnt", 64'(bus.i_gnt), 64'd1);
        chk("postrst_i_rdata", 64'(bus.i_rdata), 64'd0);
        tick();

        // Idle for 5 cycles.
        idle_in();
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("idle_gnt", 64'({bus.i_gnt, bus.d_gnt, bus.mem_en_write}), 64'd0);
        end
        chk("idle_i_rdata", 64'(bus.i_rdata), 64'h9999_0009);

        // Lock dropped with no access: next tie goes to fetch.
        set_in(1'b0, 30'h0, 1'b1, 1'b0, 1'b1, 30'h50, 32'h0, 32'hC0DE_0003);
        tick();
        set_in(1'b0, 30'h0, 1'b0, 1'b0, 1'b0, 30'h50, 32'h0, 32'h0);
        tick();
        set_in(1'b1, 30'h1C, 1'b1, 1'b0, 1'b0, 30'h54, 32'h0, 32'h6666_0006);
        chk("unlock_tie_i_gnt", 64'(bus.i_gnt), 64'd1);
        tick();

        // Back-to-back fetches with data idle.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 30'h100 + AW'(k), 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 32'hF000_0000 + DW'(k));
            chk("b2b_i_gnt", 64'(bus.i_gnt), 64'd1);
            tick();
        end
        idle_in();
        chk("b2b_i_rdata", 64'(bus.i_rdata), 64'hF000_0002);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
